// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking lane detectors.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S_A  = 2'd1,
    S_AB = 2'd2,
    S_B  = 2'd3
  } lane_state_e;

  localparam int unsigned LANE_ENTRY = 0;
  localparam int unsigned LANE_EXIT  = 1;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_TRANSIT_TIMEOUT = 1000;
  localparam int unsigned DEF_PEND_W          = 3;

endpackage

// File: rtl/lane_detector.sv
// One lane: two beam conditioners, transit FSM, pending counter, gate ack detect.
// Optional transit timeout built when DETECTOR_TIMEOUT_EN is defined.
module lane_detector
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TRANSIT_TIMEOUT = DEF_TRANSIT_TIMEOUT,
  parameter int unsigned PEND_W          = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beam_a,
  input  logic              beam_b,
  input  logic              gate,
  output logic              sensor,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              fault
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 carries beam A, bit 1 carries beam B.
  logic [1:0]       sync1_q, sync2_q, filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  lane_state_e      state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic             gate_q;
  logic             overflow_q, overflow_d;
  logic             transit, ack, dec;
  logic             fa, fb;

`ifdef DETECTOR_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TRANSIT_TIMEOUT + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             fault_q, timeout;
`endif

  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == DB_LAST) filt_d[i] = sync2_q[i];
        else                     cnt_d[i]  = cnt_q[i] + 1'b1;
      end
    end
  end

  assign fa = filt_q[0];
  assign fb = filt_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      pending_q  <= '0;
      gate_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
`ifdef DETECTOR_TIMEOUT_EN
      timer_q    <= '0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= {beam_b, beam_a};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      pending_q  <= pending_d;
      gate_q     <= gate;
      overflow_q <= overflow_d;
      for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
`ifdef DETECTOR_TIMEOUT_EN
      timer_q    <= timer_d;
      fault_q    <= timeout;
`endif
    end
  end

`ifdef DETECTOR_TIMEOUT_EN
  assign timeout = (state_q != IDLE) && (timer_q == TMR_W'(TRANSIT_TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
    transit = 1'b0;
    unique case (state_q)
      IDLE: if (fa && !fb) state_d = S_A;
      S_A: begin
        if (fa && fb)        state_d = S_AB;
        else if (!fa && !fb) state_d = IDLE;
      end
      S_AB: begin
        if (!fa && fb)       state_d = S_B;
        else if (fa && !fb)  state_d = S_A;
        else if (!fa && !fb) state_d = IDLE;
      end
      S_B: begin
        if (!fa && !fb) begin
          state_d = IDLE;
          transit = 1'b1;
        end else if (fa && fb) begin
          state_d = S_AB;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef DETECTOR_TIMEOUT_EN
    if (timeout) begin
      state_d = IDLE;
      transit = 1'b0;
    end
    timer_d = '0;
    if ((state_q != IDLE) && (state_d == state_q)) timer_d = timer_q + 1'b1;
`endif

    ack        = gate && !gate_q;
    dec        = ack && (pending_q != '0);
    pending_d  = pending_q;
    overflow_d = 1'b0;
    if (transit && !dec) begin
      if (pending_q == '1) overflow_d = 1'b1;
      else                 pending_d  = pending_q + 1'b1;
    end else if (!transit && dec) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_comb begin
    sensor   = (pending_q != '0);
    pending  = pending_q;
    overflow = overflow_q;
`ifdef DETECTOR_TIMEOUT_EN
    fault    = fault_q;
`else
    fault    = 1'b0;
`endif
  end

endmodule

// File: rtl/vehicle_detector.sv
// Entry/exit lane transit detector feeding the parking controller.
// Transit timeout enabled by defining DETECTOR_TIMEOUT_EN.
module vehicle_detector
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TRANSIT_TIMEOUT = DEF_TRANSIT_TIMEOUT,
  parameter int unsigned PEND_W          = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              entry_a,
  input  logic              entry_b,
  input  logic              exit_a,
  input  logic              exit_b,
  input  logic              entry_gate,
  input  logic              exit_gate,
  output logic              entry_sensor,
  output logic              exit_sensor,
  output logic [PEND_W-1:0] entry_pending,
  output logic [PEND_W-1:0] exit_pending,
  output logic [1:0]        overflow,
  output logic [1:0]        lane_fault
);

  lane_detector #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .TRANSIT_TIMEOUT(TRANSIT_TIMEOUT),
    .PEND_W         (PEND_W)
  ) u_entry (
    .clk     (clk),
    .reset   (reset),
    .beam_a  (entry_a),
    .beam_b  (entry_b),
    .gate    (entry_gate),
    .sensor  (entry_sensor),
    .pending (entry_pending),
    .overflow(overflow[LANE_ENTRY]),
    .fault   (lane_fault[LANE_ENTRY])
  );

  lane_detector #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .TRANSIT_TIMEOUT(TRANSIT_TIMEOUT),
    .PEND_W         (PEND_W)
  ) u_exit (
    .clk     (clk),
    .reset   (reset),
    .beam_a  (exit_a),
    .beam_b  (exit_b),
    .gate    (exit_gate),
    .sensor  (exit_sensor),
    .pending (exit_pending),
    .overflow(overflow[LANE_EXIT]),
    .fault   (lane_fault[LANE_EXIT])
  );

endmodule

// File: tb/tb_vehicle_detector.sv
// Directed bench for vehicle_detector (DEBOUNCE_CYCLES=4, PEND_W=2, TRANSIT_TIMEOUT=50).
module tb_vehicle_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_a, entry_b, exit_a, exit_b, entry_gate, exit_gate;
  logic       entry_sensor, exit_sensor;
  logic [1:0] entry_pending, exit_pending, overflow, lane_fault;

  int compared   = 0;
  int mismatched = 0;

  vehicle_detector #(
    .DEBOUNCE_CYCLES(4),
    .TRANSIT_TIMEOUT(50),
    .PEND_W         (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .entry_a      (entry_a),
    .entry_b      (entry_b),
    .exit_a       (exit_a),
    .exit_b       (exit_b),
    .entry_gate   (entry_gate),
    .exit_gate    (exit_gate),
    .entry_sensor (entry_sensor),
    .exit_sensor  (exit_sensor),
    .entry_pending(entry_pending),
    .exit_pending (exit_pending),
    .overflow     (overflow),
    .lane_fault   (lane_fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beams(input bit lane, input logic a, input logic b, input int n);
    if (lane) begin exit_a = a;  exit_b = b;  end
    else      begin entry_a = a; entry_b = b; end
    tick(n);
  endtask

  // Full A, AB, B, clear sequence; 'last' cycles spent after the final clear.
  task automatic transit(input bit lane, input int last);
    beams(lane, 1'b1, 1'b0, 8);
    beams(lane, 1'b1, 1'b1, 8);
    beams(lane, 1'b0, 1'b1, 8);
    beams(lane, 1'b0, 1'b0, last);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ep"}, 32'(entry_pending), 32'd0);
    check({tag, "_xp"}, 32'(exit_pending), 32'd0);
    check({tag, "_es"}, 32'(entry_sensor), 32'd0);
    check({tag, "_xs"}, 32'(exit_sensor), 32'd0);
    check({tag, "_ov"}, 32'(overflow), 32'd0);
    check({tag, "_lf"}, 32'(lane_fault), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    entry_a = 1'b0; entry_b = 1'b0; exit_a = 1'b0; exit_b = 1'b0;
    entry_gate = 1'b0; exit_gate = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Clean entry transit: count updates 2+4+1 edges after the final clear.
    transit(1'b0, 6);
    check("lat_pre", 32'(entry_pending), 32'd0);
    tick(1);
    check("cnt_one", 32'(entry_pending), 32'd1);
    check("req_hi", 32'(entry_sensor), 32'd1);
    tick(10);
    entry_gate = 1'b1;
    check("req_before_ack", 32'(entry_sensor), 32'd1);
    tick(1);
    check("ack_cnt", 32'(entry_pending), 32'd0);
    check("ack_req_lo", 32'(entry_sensor), 32'd0);
    entry_gate = 1'b0;
    tick(2);

    // Short glitches on A, then a probe that would count only from S_A.
    for (int i = 0; i < 3; i++) begin
      beams(1'b0, 1'b1, 1'b0, 3);
      beams(1'b0, 1'b0, 1'b0, 3);
    end
    tick(8);
    beams(1'b0, 1'b1, 1'b1, 8);
    beams(1'b0, 1'b0, 1'b1, 8);
    beams(1'b0, 1'b0, 1'b0, 10);
    check("glitch", 32'(entry_pending), 32'd0);

    // Aborted transit.
    beams(1'b0, 1'b1, 1'b0, 8);
    beams(1'b0, 1'b1, 1'b1, 8);
    beams(1'b0, 1'b1, 1'b0, 8);
    beams(1'b0, 1'b0, 1'b0, 10);
    check("abort", 32'(entry_pending), 32'd0);

    // Wrong-way vehicle.
    beams(1'b0, 1'b0, 1'b1, 8);
    beams(1'b0, 1'b1, 1'b1, 8);
    beams(1'b0, 1'b1, 1'b0, 8);
    beams(1'b0, 1'b0, 1'b0, 10);
    check("wrong_way", 32'(entry_pending), 32'd0);

    // Saturation at 3 with PEND_W=2.
    transit(1'b0, 8);
    check("sat_1", 32'(entry_pending), 32'd1);
    transit(1'b0, 8);
    check("sat_2", 32'(entry_pending), 32'd2);
    transit(1'b0, 8);
    check("sat_3", 32'(entry_pending), 32'd3);
    transit(1'b0, 6);
    check("ovf_pre", 32'(overflow), 32'd0);
    tick(1);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(entry_pending), 32'd3);
    tick(1);
    check("ovf_end", 32'(overflow), 32'd0);

    // Transit coinciding with an ack at saturation.
    transit(1'b0, 6);
    entry_gate = 1'b1;
    tick(1);
    check("sat_ack_cnt", 32'(entry_pending), 32'd3);
    check("sat_ack_ovf", 32'(overflow), 32'd0);
    entry_gate = 1'b0;
    tick(2);

    // Exit lane works independently.
    transit(1'b1, 8);
    check("exit_cnt", 32'(exit_pending), 32'd1);
    check("exit_req", 32'(exit_sensor), 32'd1);
    check("entry_kept", 32'(entry_pending), 32'd3);
    exit_gate = 1'b1;
    tick(1);
    check("exit_ack", 32'(exit_pending), 32'd0);
    exit_gate = 1'b0;
    tick(2);

`ifdef DETECTOR_TIMEOUT_EN
    exit_a = 1'b1;
    tick(56);
    check("tmo_pre", 32'(lane_fault), 32'd0);
    tick(1);
    check("tmo_pulse", 32'(lane_fault), 32'd2);
    tick(1);
    check("tmo_end", 32'(lane_fault), 32'd0);
`else
    exit_a = 1'b1;
    tick(60);
    check("no_fault", 32'(lane_fault), 32'd0);
`endif
    exit_a = 1'b0;
    tick(12);
    check("tmo_no_cnt", 32'(exit_pending), 32'd0);

    // Reset mid-transit with two queued transits.
    entry_gate = 1'b1;
    tick(1);
    check("pre_rst_cnt", 32'(entry_pending), 32'd2);
    entry_gate = 1'b0;
    beams(1'b0, 1'b1, 1'b0, 8);
    reset = 1'b1;
    tick(1);
    check_all_zero("mid_rst");
    reset = 1'b0;
    entry_a = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vehicle_detector.md
# vehicle_detector

Front-end lane detector that sits directly upstream of the smart parking controller. It conditions raw dual-beam sensors on the entry and exit lanes and qualifies a full vehicle transit. Each counted transit becomes a held request (`entry_sensor` / `exit_sensor`) that stays asserted until the controller opens the matching gate. Queued transits are kept in a small per-lane pending counter, so no vehicle is lost while a gate is busy.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronized samples required before a filtered beam changes.
- `TRANSIT_TIMEOUT`, default 1000: maximum number of cycles a lane may stay in a non-IDLE state. Used only with the macro.
- `PEND_W`, default 3: width of each pending counter. Saturates at 2^PEND_W−1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `entry_a`, `entry_b`  in  1 each  raw entry-lane beams; 1 = blocked. `a` is the outer beam.
- `exit_a`, `exit_b`  in  1 each  raw exit-lane beams; `a` is the inner beam (vehicle leaving breaks `a` first).
- `entry_gate`, `exit_gate`  in  1 each  gate states fed back from the parking controller.
- `entry_sensor`, `exit_sensor`  out  1 each  request to the controller; high while the lane's pending count ≠ 0.
- `entry_pending`, `exit_pending`  out  PEND_W each  queued transit counts.
- `overflow`  out  2  one-cycle pulse per lane (bit0 entry, bit1 exit) when a transit is dropped at saturation.
- `lane_fault`  out  2  one-cycle pulse per lane on transit timeout.

## Operation
- **Per beam conditioning:**
  - Raw input passes through a 2-flop synchronizer, then a debounce counter.
  - The filtered value changes only after DEBOUNCE_CYCLES consecutive samples that differ from the current filtered value.
  - Any sample equal to the filtered value resets the counter.
- **Per-lane FSM** on the filtered beams (A, B):
  - IDLE: A&!B → S_A. B-only is a wrong-way vehicle: stay IDLE, no event.
  - S_A: A&B → S_AB. Both clear → IDLE (abort, no event).
  - S_AB: !A&B → S_B. A&!B → S_A (backing out). Both clear → IDLE (no event).
  - S_B: both clear → IDLE **and count one transit**. A&B → S_AB (reversing).
  - Any combination not listed holds the current state.
- **Pending counter:**
  - Increments on a counted transit.
  - Decrements on gate acknowledge: the gate input sampled 0 on the previous cycle and 1 on the current cycle (rising edge detected with a registered copy).
  - A counted transit and an ack in the same cycle leave the count unchanged.
  - An ack with count 0 is ignored.
  - A transit at saturation is dropped and pulses `overflow`, unless an ack occurs in the same cycle, in which case the count is unchanged and there is no overflow.
- **Held requests:** the request stays high while the lot is full. The controller ignores it until a space frees and then consumes it; no request is dropped for that reason.

## Timing
- **Reset values:** all outputs are 0. Filtered beams reset to 0 (unblocked), FSMs reset to IDLE, and counters, the timeout timer and the gate edge registers reset to 0.
- **Reset mid-transit:** any queued count is discarded.
- **Raw-to-filtered latency:** 2 + DEBOUNCE_CYCLES cycles.
- **State transitions:** the FSM moves on the clock edge after the filtered value changes.
- **Counted transit:** the pending counter updates on the same edge the FSM enters IDLE from S_B. `*_sensor` is combinational from the pending register, so it is high in the cycle after that edge.
- **Ack to deassert:** the decrement happens on the edge that samples the gate rising. With a count of 1, `*_sensor` is low in the following cycle.
- **Lane independence:** the two lanes are fully independent; simultaneous events on both lanes are all honoured.

## Configuration
- `DETECTOR_TIMEOUT_EN` defined:
  - A per-lane timer counts cycles in non-IDLE states and reloads on every state change.
  - When it reaches TRANSIT_TIMEOUT, the FSM returns to IDLE with no event and pulses `lane_fault`.
- `DETECTOR_TIMEOUT_EN` undefined:
  - No timer is built; the FSM waits indefinitely.
  - `lane_fault` is tied to 0.

## Structure
- **Shared package `parking_pkg`:**
  - Lane state enum (IDLE, S_A, S_AB, S_B).
  - Lane index constants (`LANE_ENTRY` = 0, `LANE_EXIT` = 1).
  - Default DEBOUNCE_CYCLES, TRANSIT_TIMEOUT and PEND_W values.
- **Sub-module `lane_detector`:** contains both beam conditioners, the FSM, the optional timer, the pending counter and the ack edge detect. It is instantiated twice.
- **Top level:** wiring and output concatenation only.

## Test plan
- Clean entry transit with DEBOUNCE_CYCLES=4, and gate pulsed 10 cycles after the request → `entry_pending` goes 0→1 and `entry_sensor` rises, then the count returns to 0 and `entry_sensor` drops one cycle after the gate's rising edge.
- 3-cycle glitches on `entry_a` with DEBOUNCE_CYCLES=4 → no FSM movement and pending stays 0.
- Aborted transit (A, A&B, A, clear) plus a wrong-way transit (B first) → no count.
- PEND_W=2 with four transits and no gate activity → count saturates at 3; the fourth transit pulses `overflow[0]`. A transit coinciding with an ack leaves the count at 3 with no overflow.
- With the macro defined and TRANSIT_TIMEOUT=50, `exit_a` held blocked → `lane_fault[1]` pulses after 50 cycles in S_A, the FSM returns to IDLE, and there is no count. Without the macro, `lane_fault` stays 0.
- Reset asserted with `entry_pending`=2 mid-transit → all outputs are 0 on the next cycle.
